// File: rtl/contrast_status_sequencer.sv
// Snapshots per-box PWM on-values plus a 36-bit timestamp on each trigger and
// streams them out as one fixed-format record of 18-bit words (valid/ready).
module contrast_status_sequencer #(
  parameter int NUMBER_OF_BOXES = 2,
  parameter int PWM_REG_WIDTH   = 10
) (
  input  logic                                     clk_peri,
  input  logic                                     reset,
  input  logic                                     enable,
  input  logic                                     trigger,
  input  logic [NUMBER_OF_BOXES*PWM_REG_WIDTH-1:0] pwm_values,
  output logic [17:0]                              out_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     out_last,
  output logic                                     busy
);

  localparam int PWM_BITS = NUMBER_OF_BOXES * PWM_REG_WIDTH;
  localparam logic [2:0] LAST_BOX = 3'(NUMBER_OF_BOXES - 1);

  typedef enum logic [2:0] {IDLE, HDR, TSH, TSL, BOX} state_t;

  state_t              state;
  logic [2:0]          box_idx;
  logic [35:0]         timestamp;
  logic [35:0]         shadow_ts;
  logic [PWM_BITS-1:0] shadow_pwm;
  logic                pending;
  logic [7:0]          drops;
  logic [4:0]          seq;

  logic        xfer;
  logic        last_xfer;
  logic        hdr_xfer;
  logic        trig;
  logic        launch;
  logic        pend_evt;
  logic        drop_evt;
  logic [17:0] header_word;

  function automatic logic [17:0] box_word(input logic [PWM_BITS-1:0] values,
                                           input logic [2:0] idx);
    box_word = 18'(values[PWM_REG_WIDTH*idx +: PWM_REG_WIDTH]);
  endfunction

  // A launch either starts from idle or chains straight onto the last word so
  // back-to-back records have no bubble; triggers that cannot launch are pended
  // once and counted as drops after that.
  always_comb begin
    xfer        = out_valid && out_ready;
    last_xfer   = xfer && out_last;
    hdr_xfer    = xfer && (state == HDR);
    trig        = enable && trigger;
    launch      = ((state == IDLE) && trig) || (last_xfer && (pending || trig));
    pend_evt    = (state != IDLE) && trig && !launch && !pending;
    drop_evt    = (state != IDLE) && trig && !launch && pending;
    header_word = {2'b10, LAST_BOX, seq, drops};
    busy        = (state != IDLE);
  end

  always_ff @(posedge clk_peri) begin
    if (reset) begin
      state      <= IDLE;
      box_idx    <= '0;
      timestamp  <= '0;
      shadow_ts  <= '0;
      shadow_pwm <= '0;
      pending    <= 1'b0;
      drops      <= '0;
      seq        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      timestamp <= timestamp + 36'd1;

      if (launch) begin
        shadow_ts  <= timestamp;
        shadow_pwm <= pwm_values;
        pending    <= 1'b0;
      end else if (pend_evt) begin
        pending <= 1'b1;
      end

      // The header already carries the latched count, so it restarts on transfer.
      if (hdr_xfer) begin
        drops <= drop_evt ? 8'd1 : 8'd0;
        seq   <= seq + 5'd1;
      end else if (drop_evt && (drops != 8'hFF)) begin
        drops <= drops + 8'd1;
      end

      case (state)
        IDLE: begin
          if (launch) begin
            state     <= HDR;
            out_data  <= header_word;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end
        end
        HDR: begin
          if (xfer) begin
            state    <= TSH;
            out_data <= shadow_ts[35:18];
          end
        end
        TSH: begin
          if (xfer) begin
            state    <= TSL;
            out_data <= shadow_ts[17:0];
          end
        end
        TSL: begin
          if (xfer) begin
            state    <= BOX;
            box_idx  <= 3'd0;
            out_data <= box_word(shadow_pwm, 3'd0);
            out_last <= (LAST_BOX == 3'd0);
          end
        end
        BOX: begin
          if (xfer) begin
            if (out_last) begin
              if (launch) begin
                state    <= HDR;
                out_data <= header_word;
                out_last <= 1'b0;
              end else begin
                state     <= IDLE;
                out_data  <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
              end
            end else begin
              box_idx  <= box_idx + 3'd1;
              out_data <= box_word(shadow_pwm, box_idx + 3'd1);
              out_last <= ((box_idx + 3'd1) == LAST_BOX);
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_contrast_status_sequencer.sv
// Directed bench for contrast_status_sequencer (2 boxes, 10-bit PWM values):
// each record is compared word by word against hand-built expectations.
module tb_contrast_status_sequencer;

  typedef logic [17:0] rec_t [5];

  logic        clk_peri = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        trigger = 1'b0;
  logic [19:0] pwm_values = '0;
  logic [17:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;

  logic [35:0] tb_ts = '0;
  int          vectors = 0;
  int          miscompares = 0;

  contrast_status_sequencer #(.NUMBER_OF_BOXES(2), .PWM_REG_WIDTH(10)) dut (
    .clk_peri  (clk_peri),
    .reset     (reset),
    .enable    (enable),
    .trigger   (trigger),
    .pwm_values(pwm_values),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk_peri = ~clk_peri;

  // Reference free-running timestamp, used to predict snapshot values.
  always @(posedge clk_peri) begin
    if (reset) tb_ts <= '0;
    else       tb_ts <= tb_ts + 36'd1;
  end

  task automatic checkOutput(input string tag, input logic [35:0] observed,
                             input logic [35:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic trig, input logic rdy,
                               input logic [19:0] pwm);
    enable     = en;
    trigger    = trig;
    out_ready  = rdy;
    pwm_values = pwm;
  endtask

  function automatic rec_t makeRecord(input logic [4:0] seq, input logic [7:0] drops,
                                      input logic [35:0] ts, input logic [19:0] pwm);
    rec_t r;
    r[0] = {2'b10, 3'd1, seq, drops};
    r[1] = ts[35:18];
    r[2] = ts[17:0];
    r[3] = {8'd0, pwm[9:0]};
    r[4] = {8'd0, pwm[19:10]};
    return r;
  endfunction

  // Walks one record from word start_idx; ready is high one cycle in stall_mod
  // (always when 0). Returns the reference timestamp of the last-word transfer cycle.
  task automatic getRecord(input rec_t want, input int start_idx, input int stall_mod,
                           input bit scramble, input string tag,
                           output logic [35:0] ts_last);
    int idx = start_idx;
    int c = 0;
    ts_last = '0;
    while (idx < 5 && c < 400) begin
      out_ready = (stall_mod == 0) || (c % stall_mod == 0);
      if (scramble) pwm_values = 20'($urandom);
      if (out_valid) begin
        checkOutput($sformatf("%s_w%0d", tag, idx), {18'd0, out_data}, {18'd0, want[idx]});
        checkOutput($sformatf("%s_last%0d", tag, idx), {35'd0, out_last}, {35'd0, idx == 4});
        if (out_ready) begin
          if (idx == 4) ts_last = tb_ts;
          idx++;
        end
      end else begin
        checkOutput($sformatf("%s_valid%0d", tag, idx), {35'd0, out_valid}, 36'd1);
        c = 400;
      end
      c++;
      @(negedge clk_peri);
    end
    if (idx < 5) checkOutput($sformatf("%s_timeout", tag), 36'(idx), 36'd5);
  endtask

  initial begin
    rec_t        want;
    logic [35:0] ts_snap;
    logic [35:0] ts_next;
    logic [19:0] pwm_a;
    logic [19:0] pwm_b;
    pwm_a = {10'h0F0, 10'h00F};
    pwm_b = {10'h2C3, 10'h1A5};

    // Reset state
    repeat (3) @(negedge clk_peri);
    checkOutput("rst_valid", {35'd0, out_valid}, 36'd0);
    checkOutput("rst_last", {35'd0, out_last}, 36'd0);
    checkOutput("rst_data", {18'd0, out_data}, 36'd0);
    checkOutput("rst_busy", {35'd0, busy}, 36'd0);
    reset = 1'b0;

    // Basic record, trigger when the timestamp reads 5
    repeat (5) @(negedge clk_peri);
    applyStimulus(1'b1, 1'b1, 1'b1, {10'h3FF, 10'h012});
    @(negedge clk_peri);
    applyStimulus(1'b1, 1'b0, 1'b1, {10'h3FF, 10'h012});
    checkOutput("t1_busy", {35'd0, busy}, 36'd1);
    want = '{18'h22000, 18'h00000, 18'h00005, 18'h00012, 18'h003FF};
    getRecord(want, 0, 0, 1'b0, "t1", ts_next);
    checkOutput("t1_idle", {35'd0, busy}, 36'd0);
    checkOutput("t1_novalid", {35'd0, out_valid}, 36'd0);

    // Stalled record with pwm_values changing underneath
    applyStimulus(1'b1, 1'b1, 1'b1, {10'h155, 10'h2AA});
    ts_snap = tb_ts;
    @(negedge clk_peri);
    applyStimulus(1'b1, 1'b0, 1'b1, {10'h155, 10'h2AA});
    want = makeRecord(5'd1, 8'd0, ts_snap, {10'h155, 10'h2AA});
    getRecord(want, 0, 3, 1'b1, "t2", ts_next);
    checkOutput("t2_idle", {35'd0, busy}, 36'd0);

    // Three triggers during one record: one pended, two dropped
    reset = 1'b1;
    repeat (2) @(negedge clk_peri);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, pwm_a);
    ts_snap = tb_ts;
    @(negedge clk_peri);
    applyStimulus(1'b1, 1'b0, 1'b1, pwm_a);
    want = makeRecord(5'd0, 8'd0, ts_snap, pwm_a);
    fork
      getRecord(want, 0, 0, 1'b0, "t3a", ts_next);
      begin
        @(negedge clk_peri);
        trigger = 1'b1;
        repeat (3) @(negedge clk_peri);
        trigger = 1'b0;
        pwm_values = pwm_b;
      end
    join
    checkOutput("t3_chain", {35'd0, out_valid}, 36'd1);
    want = makeRecord(5'd1, 8'd2, ts_next, pwm_b);
    getRecord(want, 0, 0, 1'b0, "t3b", ts_next);
    checkOutput("t3_idle", {35'd0, busy}, 36'd0);

    // 300 triggers during a long stall saturate the drop counter
    applyStimulus(1'b1, 1'b1, 1'b1, pwm_a);
    ts_snap = tb_ts;
    @(negedge clk_peri);
    applyStimulus(1'b1, 1'b0, 1'b1, pwm_a);
    want = makeRecord(5'd2, 8'd0, ts_snap, pwm_a);
    checkOutput("t4c_w0", {18'd0, out_data}, {18'd0, want[0]});
    @(negedge clk_peri);
    applyStimulus(1'b1, 1'b1, 1'b0, pwm_a);
    repeat (300) @(negedge clk_peri);
    applyStimulus(1'b1, 1'b0, 1'b1, pwm_a);
    getRecord(want, 1, 0, 1'b0, "t4c", ts_next);
    want = makeRecord(5'd3, 8'd255, ts_next, pwm_a);
    getRecord(want, 0, 0, 1'b0, "t4d", ts_next);
    applyStimulus(1'b1, 1'b1, 1'b1, pwm_a);
    ts_snap = tb_ts;
    @(negedge clk_peri);
    applyStimulus(1'b1, 1'b0, 1'b1, pwm_a);
    want = makeRecord(5'd4, 8'd0, ts_snap, pwm_a);
    getRecord(want, 0, 0, 1'b0, "t4e", ts_next);

    // Disabled triggers are ignored
    applyStimulus(1'b0, 1'b1, 1'b1, pwm_a);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_peri);
      checkOutput("t5_dis_valid", {35'd0, out_valid}, 36'd0);
      checkOutput("t5_dis_busy", {35'd0, busy}, 36'd0);
    end

    // Enable dropped mid-record with nothing pending: record completes, nothing follows
    applyStimulus(1'b1, 1'b1, 1'b1, pwm_a);
    ts_snap = tb_ts;
    @(negedge clk_peri);
    applyStimulus(1'b1, 1'b0, 1'b1, pwm_a);
    want = makeRecord(5'd5, 8'd0, ts_snap, pwm_a);
    fork
      getRecord(want, 0, 0, 1'b0, "t5f", ts_next);
      begin
        @(negedge clk_peri);
        enable = 1'b0;
        trigger = 1'b1;
      end
    join
    checkOutput("t5f_idle", {35'd0, busy}, 36'd0);
    @(negedge clk_peri);
    checkOutput("t5f_novalid", {35'd0, out_valid}, 36'd0);

    // Pending set before enable drops: the pended record still launches
    applyStimulus(1'b1, 1'b1, 1'b1, pwm_a);
    ts_snap = tb_ts;
    @(negedge clk_peri);
    applyStimulus(1'b1, 1'b0, 1'b1, pwm_a);
    want = makeRecord(5'd6, 8'd0, ts_snap, pwm_a);
    fork
      getRecord(want, 0, 0, 1'b0, "t5g", ts_next);
      begin
        @(negedge clk_peri);
        trigger = 1'b1;
        @(negedge clk_peri);
        enable = 1'b0;
      end
    join
    want = makeRecord(5'd7, 8'd0, ts_next, pwm_a);
    getRecord(want, 0, 0, 1'b0, "t5h", ts_next);
    checkOutput("t5h_idle", {35'd0, busy}, 36'd0);

    // Reset during the third word aborts the record and restarts seq/timestamp
    applyStimulus(1'b1, 1'b1, 1'b1, pwm_a);
    @(negedge clk_peri);
    applyStimulus(1'b1, 1'b0, 1'b1, pwm_a);
    repeat (2) @(negedge clk_peri);
    reset = 1'b1;
    @(negedge clk_peri);
    checkOutput("t6_rst_valid", {35'd0, out_valid}, 36'd0);
    checkOutput("t6_rst_busy", {35'd0, busy}, 36'd0);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, pwm_b);
    @(negedge clk_peri);
    applyStimulus(1'b1, 1'b0, 1'b1, pwm_b);
    want = makeRecord(5'd0, 8'd0, 36'd0, pwm_b);
    getRecord(want, 0, 0, 1'b0, "t6", ts_next);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
